// File: rtl/op_dispatch_pipe_pkg.sv
// Shared types for the bf16 op dispatch pipe: op codes, bf16 layout, and the
// per-result response record carried through the pipe and response FIFO.
package data_type_pkg;

  localparam int MODE_WIDTH = 2;

  localparam logic [MODE_WIDTH-1:0] MODE_ADD = 2'd0;
  localparam logic [MODE_WIDTH-1:0] MODE_MUL = 2'd1;
  localparam logic [MODE_WIDTH-1:0] MODE_SUB = 2'd2;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  // Tag is appended by the user of this record, since its width is a module parameter.
  typedef struct packed {
    bf16_t data;
    logic  ovf;
    logic  err;
  } rsp_entry_t;

  // Subtraction is an add with the second operand's sign inverted.
  function automatic bf16_t bf16_negate(input bf16_t x);
    bf16_t r;
    r      = x;
    r.sign = ~x.sign;
    return r;
  endfunction

endpackage

// File: rtl/op_dispatch_pipe_if.sv
// Operand/result bundle between the dispatcher and one combinational bf16 unit.
interface op_intf;
  import data_type_pkg::*;

  logic       op1_sign;
  logic [7:0] op1_exp;
  logic [6:0] op1_frac;
  logic       op2_sign;
  logic [7:0] op2_exp;
  logic [6:0] op2_frac;
  bf16_t      result;
  logic       ovf;

  // Dispatcher side: drives operands, receives the unit's result.
  modport bus_side (
    output op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
    input  result, ovf
  );

  // Arithmetic unit side.
  modport unit_side (
    input  op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
    output result, ovf
  );

endinterface

// File: rtl/op_rsp_fifo.sv
// Synchronous show-ahead FIFO holding in-order responses. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module op_rsp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     pop_data_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW:0]    wr_q, wr_d;
  logic [AW:0]    rd_q, rd_d;

  assign empty_o    = (wr_q == rd_q);
  assign pop_data_o = mem_q[rd_q[AW-1:0]];

  // Next pointer values; a pop on an empty FIFO is ignored.
  always_comb begin
    wr_d = push_i ? wr_q + 1'b1 : wr_q;
    rd_d = (pop_i && !empty_o) ? rd_q + 1'b1 : rd_q;
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write.
  // NOTE: the array is deliberately left out of reset; the pointers define which
  // entries are meaningful, and the top masks the head while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/op_dispatch_pipe.sv
// Pipelined, credit flow-controlled bf16 op dispatcher: issue register S0 steers
// operands to the add or mul unit, results shift through PIPE_STAGES registers
// into an in-order response FIFO. Optional feature macro:
// OP_DISPATCH_OVF_STICKY_EN adds a sticky overflow flag with a clear input.
module op_dispatch_pipe
  import data_type_pkg::*;
#(
  parameter int PIPE_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [MODE_WIDTH-1:0] req_op_i,
  input  bf16_t                 req_in1_i,
  input  bf16_t                 req_in2_i,
  input  logic [TAG_W-1:0]      req_tag_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output bf16_t                 rsp_data_o,
  output logic                  rsp_ovf_o,
  output logic                  rsp_err_o,
  output logic [TAG_W-1:0]      rsp_tag_o,
  output logic                  idle_o,
  op_intf.bus_side              add_intf,
  op_intf.bus_side              mul_intf
`ifdef OP_DISPATCH_OVF_STICKY_EN
  ,
  output logic                  ovf_sticky_o,
  input  logic                  ovf_clr_i
`endif
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic                  v;
    logic [MODE_WIDTH-1:0] op;
    bf16_t                 in1;
    bf16_t                 in2;
    logic [TAG_W-1:0]      tag;
  } issue_t;

  typedef struct packed {
    rsp_entry_t       rsp;
    logic [TAG_W-1:0] tag;
  } fifo_entry_t;

  issue_t                 s0_q, s0_d;
  fifo_entry_t            unit_rsp;
  fifo_entry_t            pipe_q [PIPE_STAGES];
  fifo_entry_t            pipe_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] pipe_v_q, pipe_v_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   idle_q, idle_d;
  logic                   accept, pop, fifo_empty;
  fifo_entry_t            fifo_head;

  assign accept      = req_valid_i & ready_q;
  assign rsp_valid_o = ~fifo_empty;
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign req_ready_o = ready_q;
  assign idle_o      = idle_q;

  // Issue register: captures the request on accept, otherwise holds with v cleared.
  // NOTE: every always_comb starts from a full default so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    s0_d   = s0_q;
    s0_d.v = accept;
    if (accept) begin
      s0_d.op  = req_op_i;
      s0_d.in1 = req_in1_i;
      s0_d.in2 = req_in2_i;
      s0_d.tag = req_tag_i;
    end
  end

  // Steer S0 operands to exactly one unit; the idle unit sees all-zero operands.
  always_comb begin
    {add_intf.op1_sign, add_intf.op1_exp, add_intf.op1_frac} = '0;
    {add_intf.op2_sign, add_intf.op2_exp, add_intf.op2_frac} = '0;
    {mul_intf.op1_sign, mul_intf.op1_exp, mul_intf.op1_frac} = '0;
    {mul_intf.op2_sign, mul_intf.op2_exp, mul_intf.op2_frac} = '0;
    if (s0_q.v) begin
      case (s0_q.op)
        MODE_ADD: begin
          {add_intf.op1_sign, add_intf.op1_exp, add_intf.op1_frac} = s0_q.in1;
          {add_intf.op2_sign, add_intf.op2_exp, add_intf.op2_frac} = s0_q.in2;
        end
        MODE_SUB: begin
          {add_intf.op1_sign, add_intf.op1_exp, add_intf.op1_frac} = s0_q.in1;
          {add_intf.op2_sign, add_intf.op2_exp, add_intf.op2_frac} = bf16_negate(s0_q.in2);
        end
        MODE_MUL: begin
          {mul_intf.op1_sign, mul_intf.op1_exp, mul_intf.op1_frac} = s0_q.in1;
          {mul_intf.op2_sign, mul_intf.op2_exp, mul_intf.op2_frac} = s0_q.in2;
        end
        default: ;
      endcase
    end
  end

  // Pick the active unit's result; an illegal op yields zero data with err set.
  always_comb begin
    unit_rsp     = '0;
    unit_rsp.tag = s0_q.tag;
    case (s0_q.op)
      MODE_ADD, MODE_SUB: begin
        unit_rsp.rsp.data = add_intf.result;
        unit_rsp.rsp.ovf  = add_intf.ovf;
      end
      MODE_MUL: begin
        unit_rsp.rsp.data = mul_intf.result;
        unit_rsp.rsp.ovf  = mul_intf.ovf;
      end
      default: unit_rsp.rsp.err = 1'b1;
    endcase
  end

  // Result pipe: stage 0 loads from the units, later stages shift, never stalls.
  always_comb begin
    pipe_v_d[0] = s0_q.v;
    pipe_d[0]   = unit_rsp;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_d[i]   = pipe_q[i-1];
    end
  end

  // Credits: one per FIFO slot, consumed on accept, returned on pop.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q - 1'b1;
    else if (!accept && pop) cnt_d = cnt_q + 1'b1;
    ready_d = (cnt_d != '0);
    idle_d  = (cnt_d == CNT_MAX);
  end

  // Control state with synchronous reset; in-flight ops are dropped via valid bits.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_q     <= '0;
      pipe_v_q <= '0;
      cnt_q    <= CNT_MAX;
      ready_q  <= 1'b1;
      idle_q   <= 1'b1;
    end else begin
      s0_q     <= s0_d;
      pipe_v_q <= pipe_v_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      idle_q   <= idle_d;
    end
  end

  // Pipe payload registers; meaningful only where the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_d[i];
  end

  op_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fifo_entry_t)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (pipe_v_q[PIPE_STAGES-1]),
    .push_data_i (pipe_q[PIPE_STAGES-1]),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .empty_o     (fifo_empty)
  );

  // Response outputs read as zero while nothing is presented.
  always_comb begin
    rsp_data_o = '0;
    rsp_ovf_o  = 1'b0;
    rsp_err_o  = 1'b0;
    rsp_tag_o  = '0;
    if (rsp_valid_o) begin
      rsp_data_o = fifo_head.rsp.data;
      rsp_ovf_o  = fifo_head.rsp.ovf;
      rsp_err_o  = fifo_head.rsp.err;
      rsp_tag_o  = fifo_head.tag;
    end
  end

`ifdef OP_DISPATCH_OVF_STICKY_EN
  logic sticky_q, sticky_d;

  // Sticky overflow: set on a FIFO write carrying ovf, set beats a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_clr_i) sticky_d = 1'b0;
    if (pipe_v_q[PIPE_STAGES-1] && pipe_q[PIPE_STAGES-1].rsp.ovf) sticky_d = 1'b1;
  end

  // Sticky flag register.
  always_ff @(posedge clk_i) begin
    if (rst_i) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign ovf_sticky_o = sticky_q;
`endif

endmodule

// File: tb/tb_op_dispatch_pipe.sv
// Scoreboard bench for op_dispatch_pipe: directed requests push hand-computed
// responses into a queue; a monitor pops and compares on every response handshake.
// The add/mul units are small bf16 models: exact for x+0, x*0 and the listed vectors.
module tb_op_dispatch_pipe;
  import data_type_pkg::*;

  localparam int PIPE_STAGES = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int TAG_W       = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_op_i;
  logic [15:0]       req_in1_i, req_in2_i;
  logic [TAG_W-1:0]  req_tag_i;
  logic              rsp_valid_o, rsp_ready_i;
  bf16_t             rsp_data_o;
  logic              rsp_ovf_o, rsp_err_o;
  logic [TAG_W-1:0]  rsp_tag_o;
  logic              idle_o;
`ifdef OP_DISPATCH_OVF_STICKY_EN
  logic              ovf_sticky_o;
  logic              ovf_clr_i;
`endif

  op_intf add_if ();
  op_intf mul_if ();

  op_dispatch_pipe #(
    .PIPE_STAGES (PIPE_STAGES),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TAG_W       (TAG_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_in1_i   (req_in1_i),
    .req_in2_i   (req_in2_i),
    .req_tag_i   (req_tag_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_ovf_o   (rsp_ovf_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_tag_o   (rsp_tag_o),
    .idle_o      (idle_o),
    .add_intf    (add_if),
    .mul_intf    (mul_if)
`ifdef OP_DISPATCH_OVF_STICKY_EN
    ,
    .ovf_sticky_o (ovf_sticky_o),
    .ovf_clr_i    (ovf_clr_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  // ---------------- unit models ----------------
  logic [15:0] add_a, add_b, mul_a, mul_b;
  assign add_a = {add_if.op1_sign, add_if.op1_exp, add_if.op1_frac};
  assign add_b = {add_if.op2_sign, add_if.op2_exp, add_if.op2_frac};
  assign mul_a = {mul_if.op1_sign, mul_if.op1_exp, mul_if.op1_frac};
  assign mul_b = {mul_if.op2_sign, mul_if.op2_exp, mul_if.op2_frac};

  // Returns {ovf, result}; 0x7FC0 (NaN) for operand pairs outside the table.
  function automatic logic [16:0] add_model(input logic [15:0] a, input logic [15:0] b);
    if (b[14:0] == 15'h0)                     return {1'b0, a};
    if (a[14:0] == 15'h0)                     return {1'b0, b};
    if (a == 16'h3F80 && b == 16'h4000)       return {1'b0, 16'h4040}; // 1 + 2 = 3
    if (a == 16'h4040 && b == 16'hBF80)       return {1'b0, 16'h4000}; // 3 + -1 = 2
    return {1'b0, 16'h7FC0};
  endfunction

  function automatic logic [16:0] mul_model(input logic [15:0] a, input logic [15:0] b);
    if (a[14:0] == 15'h0 || b[14:0] == 15'h0) return {1'b0, a[15] ^ b[15], 15'h0};
    if (a == 16'h4000 && b == 16'h4040)       return {1'b0, 16'h40C0}; // 2 * 3 = 6
    if (a == 16'h7F00 && b == 16'h7F00)       return {1'b1, 16'h7F80}; // overflow to +inf
    return {1'b0, 16'h7FC0};
  endfunction

  always_comb {add_if.ovf, add_if.result} = add_model(add_a, add_b);
  always_comb {mul_if.ovf, mul_if.result} = mul_model(mul_a, mul_b);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [21:0] exp_q [$];   // {data[15:0], ovf, err, tag[3:0]}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] rsp(input logic [15:0] d, input logic o, input logic e,
                                      input logic [3:0] t);
    return {d, o, e, t};
  endfunction

  // Monitor: compares each presented response that is taken by the handshake.
  initial begin : monitor
    logic [21:0] e;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i && rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {rsp_data_o, rsp_ovf_o, rsp_err_o, rsp_tag_o}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rsp_tag%0d", e[3:0]),
                {rsp_data_o, rsp_ovf_o, rsp_err_o, rsp_tag_o}, e);
        end
      end
    end
  end

  // Presents one request at a negedge, returns at the negedge after it is accepted.
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag, input logic [21:0] exp);
    int w = 0;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_in1_i   = a;
    req_in2_i   = b;
    req_tag_i   = tag;
    while (!req_ready_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    if (!req_ready_o) begin
      check("accept_timeout", 64'(req_ready_o), 64'h1);
      req_valid_i = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(negedge clk_i);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int lat;
    int idx;
    int w;
    logic acc;

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_op_i    = '0;
    req_in1_i   = '0;
    req_in2_i   = '0;
    req_tag_i   = '0;
    rsp_ready_i = 1'b1;
`ifdef OP_DISPATCH_OVF_STICKY_EN
    ovf_clr_i   = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state.
    check("rst_ready", 64'(req_ready_o), 64'h1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    check("rst_idle", 64'(idle_o), 64'h1);
    check("rst_rsp_fields", {rsp_data_o, rsp_ovf_o, rsp_err_o, rsp_tag_o}, 64'h0);
    check("rst_unit_ops", {add_a, add_b, mul_a, mul_b}, 64'h0);
`ifdef OP_DISPATCH_OVF_STICKY_EN
    check("rst_sticky", 64'(ovf_sticky_o), 64'h0);
`endif

    // ADD 1 + 2, with latency measured from the accept cycle.
    send(MODE_ADD, 16'h3F80, 16'h4000, 4'd3, rsp(16'h4040, 1'b0, 1'b0, 4'd3));
    req_valid_i = 1'b0;
    check("add_idle_low", 64'(idle_o), 64'h0);
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    check("add_latency", 64'(lat), 64'(PIPE_STAGES + 2));
    wait_drain();

    // SUB 3 - 1 then MUL 2 * 3 back-to-back; check unit steering while in S0.
    send(MODE_SUB, 16'h4040, 16'h3F80, 4'd5, rsp(16'h4000, 1'b0, 1'b0, 4'd5));
    check("sub_op2_sign", 64'(add_if.op2_sign), 64'h1);
    check("sub_add_ops", {add_a, add_b}, {32'h0, 16'h4040, 16'hBF80});
    check("sub_mul_zero", {mul_a, mul_b}, 64'h0);
    send(MODE_MUL, 16'h4000, 16'h4040, 4'd6, rsp(16'h40C0, 1'b0, 1'b0, 4'd6));
    req_valid_i = 1'b0;
    check("mul_mul_ops", {mul_a, mul_b}, {32'h0, 16'h4000, 16'h4040});
    check("mul_add_zero", {add_a, add_b}, 64'h0);
    wait_drain();

    // Eight back-to-back ops against a blocked response port: credits stop at DEPTH.
    // Even tags: ADD (0x4100+k) + 0 = 0x4100+k. Odd tags: MUL (0x4100+k) * 0 = 0.
    rsp_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid_i = (idx < 8);
      req_op_i    = idx[0] ? MODE_MUL : MODE_ADD;
      req_in1_i   = 16'h4100 + 16'(idx);
      req_in2_i   = 16'h0000;
      req_tag_i   = idx[3:0];
      acc         = req_valid_i && req_ready_o;
      if (acc) exp_q.push_back(rsp(idx[0] ? 16'h0000 : 16'h4100 + 16'(idx), 1'b0, 1'b0, idx[3:0]));
      @(negedge clk_i);
      if (acc) idx++;
    end
    check("full_accepted", 64'(idx), 64'(FIFO_DEPTH));
    check("full_ready_low", 64'(req_ready_o), 64'h0);
    check("full_idle_low", 64'(idle_o), 64'h0);
    check("full_rsp_valid", 64'(rsp_valid_o), 64'h1);

    rsp_ready_i = 1'b1;
    w = 0;
    while (idx < 8 && w < 60) begin
      req_valid_i = 1'b1;
      req_op_i    = idx[0] ? MODE_MUL : MODE_ADD;
      req_in1_i   = 16'h4100 + 16'(idx);
      req_in2_i   = 16'h0000;
      req_tag_i   = idx[3:0];
      acc         = req_ready_o;
      if (acc) exp_q.push_back(rsp(idx[0] ? 16'h0000 : 16'h4100 + 16'(idx), 1'b0, 1'b0, idx[3:0]));
      @(negedge clk_i);
      if (acc) idx++;
      w++;
    end
    req_valid_i = 1'b0;
    check("burst_all_accepted", 64'(idx), 64'h8);
    wait_drain();
    check("burst_idle", 64'(idle_o), 64'h1);

    // Illegal op code: error response, both units see zero operands.
    send(2'd3, 16'h3F80, 16'h4000, 4'd9, rsp(16'h0000, 1'b0, 1'b1, 4'd9));
    req_valid_i = 1'b0;
    check("illegal_unit_ops", {add_a, add_b, mul_a, mul_b}, 64'h0);
    wait_drain();

    // Overflowing MUL.
    send(MODE_MUL, 16'h7F00, 16'h7F00, 4'd10, rsp(16'h7F80, 1'b1, 1'b0, 4'd10));
    req_valid_i = 1'b0;
    wait_drain();
`ifdef OP_DISPATCH_OVF_STICKY_EN
    check("sticky_set", 64'(ovf_sticky_o), 64'h1);
    repeat (2) @(negedge clk_i);
    check("sticky_holds", 64'(ovf_sticky_o), 64'h1);
    ovf_clr_i = 1'b1;
    @(negedge clk_i);
    ovf_clr_i = 1'b0;
    check("sticky_cleared", 64'(ovf_sticky_o), 64'h0);
`endif

    // Reset with three ops in flight discards them.
    rsp_ready_i = 1'b0;
    send(MODE_ADD, 16'h4200, 16'h0000, 4'd1, rsp(16'h4200, 1'b0, 1'b0, 4'd1));
    send(MODE_ADD, 16'h4201, 16'h0000, 4'd2, rsp(16'h4201, 1'b0, 1'b0, 4'd2));
    send(MODE_MUL, 16'h4202, 16'h0000, 4'd3, rsp(16'h0000, 1'b0, 1'b0, 4'd3));
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    check("midrst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    check("midrst_idle", 64'(idle_o), 64'h1);
    check("midrst_ready", 64'(req_ready_o), 64'h1);
    check("midrst_unit_ops", {add_a, add_b, mul_a, mul_b}, 64'h0);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check("midrst_no_stale_rsp", 64'(rsp_valid_o), 64'h0);

    // Recovery after reset.
    rsp_ready_i = 1'b1;
    send(MODE_ADD, 16'h4280, 16'h0000, 4'd15, rsp(16'h4280, 1'b0, 1'b0, 4'd15));
    req_valid_i = 1'b0;
    wait_drain();
    check("final_idle", 64'(idle_o), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
